nmr_bstrm_simp_sramwr_seq: RTL
==============================

Name: nmr_bstrm_simp_sramwr_seq

Overview:
Bitstream-side SRAM writer: the write-direction counterpart of the bitstream SRAM reader.
- On a one-cycle START, it accepts WORD_CNT data words through a valid/ready input.
- It writes them to consecutive on-chip SRAM addresses beginning at BASE_ADDR.
- It pulses DONE when finished.
- It fills the pulse-sequence SRAM that the bitstream reader later consumes.

Parameters:
SRAM_ADDR_WIDTH, 8, SRAM address width (must match the On-Chip Memory configuration)
SRAM_DAT_WIDTH, 32, SRAM data width
SRAM_BYTEEN_WIDTH, 4, SRAM byte-enable width (SRAM_DAT_WIDTH/8)

Ports:
CLK  in  1  system clock; all logic on its rising edge
RST  in  1  reset; asynchronous, active-high
START  in  1  one-cycle pulse; begins a transfer; sampled only in IDLE
ABORT  in  1  synchronous abort; returns the block to IDLE
BASE_ADDR  in  SRAM_ADDR_WIDTH  first write address; latched on START
WORD_CNT  in  SRAM_ADDR_WIDTH+1  number of words to write; latched on START
SYS_RDY  out  1  high only in IDLE
DONE  out  1  one-cycle pulse when a transfer completes
DIN  in  SRAM_DAT_WIDTH  write data word
DIN_VALID  in  1  DIN is valid
DIN_READY  out  1  block accepts DIN this cycle
SRAM_CS  out  1  SRAM chip select, active-high
SRAM_WE  out  1  SRAM write enable, active-high
SRAM_ADDR_PHY  out  SRAM_ADDR_WIDTH  SRAM physical address
SRAM_WR_DAT  out  SRAM_DAT_WIDTH  SRAM write data
SRAM_BYTEEN  out  SRAM_BYTEEN_WIDTH  byte enables

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state=IDLE; internal address and remaining-count registers are 0.
- Reset mid-transfer: all strobes drop immediately (asynchronous). No DONE is produced. The partial SRAM contents are left as written.
- States are one-hot: IDLE, WAIT_DAT, WRITE, FIN.
- IDLE:
  - SYS_RDY=1; DIN_READY=0; CS/WE=0.
  - START=1 with WORD_CNT=0 -> FIN, with no SRAM access.
  - START=1 with WORD_CNT>0 -> latch addr<=BASE_ADDR and rem<=WORD_CNT, go to WAIT_DAT, SYS_RDY<=0.
- WAIT_DAT:
  - DIN_READY=1.
  - On DIN_VALID&DIN_READY: capture DIN into SRAM_WR_DAT, drive SRAM_ADDR_PHY<=addr, assert CS, WE and BYTEEN (all ones), DIN_READY<=0, go to WRITE.
  - DIN_VALID while DIN_READY=0 is not consumed; the source must hold the word.
- WRITE:
  - CS/WE are high for exactly this one cycle.
  - On exit: CS, WE and BYTEEN <= 0.
  - addr<=addr+1, wrapping modulo 2^SRAM_ADDR_WIDTH (0xFF -> 0x00 for the default width).
  - rem<=rem-1.
  - If rem==1 -> FIN; otherwise -> WAIT_DAT with DIN_READY<=1.
- FIN: DONE=1 for one cycle -> IDLE, with SYS_RDY<=1.
- Latency and throughput:
  - START to first DIN_READY=1: 1 cycle.
  - Accept to WE high: 1 cycle.
  - Throughput: one word per 2 cycles.
  - Last write to DONE: 1 cycle.
  - WORD_CNT=0: DONE 2 cycles after START.
- WORD_CNT=2^SRAM_ADDR_WIDTH fills the whole SRAM exactly once, with wrap from BASE_ADDR.
- START while not in IDLE is ignored.
- ABORT:
  - Priority over DIN_VALID and START in all non-IDLE states.
  - Next state is IDLE; DONE is not pulsed; DIN_READY/CS/WE <= 0.
  - A write already presented in WRITE completes in that cycle.
  - ABORT in IDLE has no effect.
- SRAM_ADDR_PHY and SRAM_WR_DAT hold their last values when CS=0.

Decomposition:
- Shared package nmr_bstrm_sram_pkg:
  - one-hot state typedef and state localparams;
  - byte-enable all-ones constant.
  - The bitstream reader reuses this package.
- No sub-module. Address/remaining counters are inline (roughly 150-200 lines of RTL).

Test Plan:
- Reset, then idle 3 cycles -> SYS_RDY=1 from the first cycle after reset; all other outputs 0.
- START, BASE_ADDR=0x10, WORD_CNT=3, DIN_VALID held high with data 0xA, 0xB, 0xC -> WE pulses at addresses 0x10, 0x11, 0x12 with the matching data, 2 cycles apart; DONE 1 cycle after the third WE; SYS_RDY=1 the cycle after DONE.
- BASE_ADDR=0xFE, WORD_CNT=4 -> writes to 0xFE, 0xFF, 0x00, 0x01.
- WORD_CNT=0 -> no CS/WE; DONE exactly 2 cycles after START.
- DIN_VALID withheld 5 cycles mid-transfer, and a second START pulsed during the transfer -> DIN_READY stays high; no WE until valid; the second START has no effect.
- ABORT asserted in WAIT_DAT after 1 of 3 words -> one write only; no DONE; SYS_RDY=1 next cycle.
- RST asserted during WRITE -> CS/WE fall without waiting for a clock edge; no DONE.

Source files
------------

// File: rtl/nmr_bstrm_sram_pkg.sv
// Shared definitions for the bitstream-side SRAM sequencers (writer and reader).
// Provides the one-hot state encoding, state bit indices and the byte-enable
// all-ones constant used when a full word is written.
package nmr_bstrm_sram_pkg;

  localparam int unsigned STATE_W = 4;

  // Bit positions of the one-hot state vector.
  localparam int unsigned ST_IDX_IDLE     = 0;
  localparam int unsigned ST_IDX_WAIT_DAT = 1;
  localparam int unsigned ST_IDX_WRITE    = 2;
  localparam int unsigned ST_IDX_FIN      = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'b0001,
    ST_WAIT_DAT = 4'b0010,
    ST_WRITE    = 4'b0100,
    ST_FIN      = 4'b1000
  } sram_seq_state_t;

  // Wide enough for any practical byte-enable width; users cast down to theirs.
  localparam int unsigned BYTEEN_MAX_W = 64;
  localparam logic [BYTEEN_MAX_W-1:0] BYTEEN_ALL_ONES = '1;

endpackage : nmr_bstrm_sram_pkg

// File: rtl/nmr_bstrm_simp_sramwr_seq.sv
// Bitstream-side SRAM writer. On a START pulse in IDLE it accepts WORD_CNT words
// over a valid/ready input and writes them to consecutive SRAM addresses starting
// at BASE_ADDR (address wraps modulo 2^SRAM_ADDR_WIDTH), then pulses DONE.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              transfer start pulse, synchronous abort
//   base_addr, word_cnt       first address and word count, latched on start
//   sys_rdy, done             idle indicator, one-cycle completion pulse
//   din, din_valid, din_ready write-data handshake
//   sram_cs, sram_we, sram_addr_phy, sram_wr_dat, sram_byteen   SRAM write port
// All outputs are registered.
module nmr_bstrm_simp_sramwr_seq
  import nmr_bstrm_sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH   = 8,
  parameter int unsigned SRAM_DAT_WIDTH    = 32,
  parameter int unsigned SRAM_BYTEEN_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [SRAM_ADDR_WIDTH-1:0]   base_addr,
  input  logic [SRAM_ADDR_WIDTH:0]     word_cnt,
  output logic                         sys_rdy,
  output logic                         done,
  input  logic [SRAM_DAT_WIDTH-1:0]    din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic                         sram_cs,
  output logic                         sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_phy,
  output logic [SRAM_DAT_WIDTH-1:0]    sram_wr_dat,
  output logic [SRAM_BYTEEN_WIDTH-1:0] sram_byteen
);

  localparam int unsigned AW = SRAM_ADDR_WIDTH;
  localparam int unsigned CW = SRAM_ADDR_WIDTH + 1;
  localparam int unsigned BW = SRAM_BYTEEN_WIDTH;

  localparam logic [BW-1:0] BE_FULL = BW'(BYTEEN_ALL_ONES);

  sram_seq_state_t state;
  logic [AW-1:0]   addr;
  logic [CW-1:0]   rem;

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      rem           <= '0;
      sys_rdy       <= 1'b0;
      done          <= 1'b0;
      din_ready     <= 1'b0;
      sram_cs       <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr_phy <= '0;
      sram_wr_dat   <= '0;
      sram_byteen   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          sys_rdy   <= 1'b1;
          din_ready <= 1'b0;
          sram_cs   <= 1'b0;
          sram_we   <= 1'b0;
          if (start) begin
            sys_rdy <= 1'b0;
            if (word_cnt == '0) begin
              state <= ST_FIN;
            end else begin
              addr      <= base_addr;
              rem       <= word_cnt;
              din_ready <= 1'b1;
              state     <= ST_WAIT_DAT;
            end
          end
        end

        ST_WAIT_DAT: begin
          if (abort) begin
            din_ready <= 1'b0;
            sys_rdy   <= 1'b1;
            state     <= ST_IDLE;
          end else if (din_valid && din_ready) begin
            sram_wr_dat   <= din;
            sram_addr_phy <= addr;
            sram_cs       <= 1'b1;
            sram_we       <= 1'b1;
            sram_byteen   <= BE_FULL;
            din_ready     <= 1'b0;
            state         <= ST_WRITE;
          end
        end

        // The strobe raised on entry is live this cycle, so the write lands even on abort.
        ST_WRITE: begin
          sram_cs     <= 1'b0;
          sram_we     <= 1'b0;
          sram_byteen <= '0;
          addr        <= addr + AW'(1);
          rem         <= rem - CW'(1);
          if (abort) begin
            sys_rdy <= 1'b1;
            state   <= ST_IDLE;
          end else if (rem == CW'(1)) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            din_ready <= 1'b1;
            state     <= ST_WAIT_DAT;
          end
        end

        // After a real transfer DONE is already high here and drops on exit.
        // A zero-length transfer arrives with DONE low, so it is raised on exit
        // instead, which places the pulse two cycles after START.
        ST_FIN: begin
          sys_rdy <= 1'b1;
          state   <= ST_IDLE;
          if (!abort) begin
            done <= ~done;
          end
        end

        default: begin
          din_ready <= 1'b0;
          sram_cs   <= 1'b0;
          sram_we   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : nmr_bstrm_simp_sramwr_seq
